// File: rtl/midi_tx.sv
// midi_tx: MIDI 1.0 transmitter, one message per handshake, 8N1 UART framing.
// Optional running-status compression when MIDI_RUNNING_STATUS_EN is defined.
module midi_tx #(
    parameter int CLKS_PER_BIT = 768,
    parameter int IDLE_GAP     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    output logic       txd,
    output logic       busy,
    output logic       byte_done,
    output logic       msg_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_TOP = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] GAP_TOP = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0] timer_q;
    logic [2:0]    bit_q;
    logic [3:0]    gap_q;
    logic [7:0]    st_q;
    logic [6:0]    d1_q;
    logic [6:0]    d2_q;
    logic [1:0]    idx_q;
    logic [1:0]    last_q;
    logic [7:0]    sh_q;
    logic          txd_q;
    logic          done_q;
    logic          err_q;

    logic          xfer;
    logic          tick;
    logic          is_cv;
    logic [1:0]    len;
    logic          rs_hit;
    logic [7:0]    cur_byte;

    assign xfer = msg_valid & msg_ready;
    assign tick = (timer_q == '0);

    // Message length from the status byte; zero marks an unsupported status.
    always_comb begin
        is_cv = msg_status[7] && (msg_status[7:4] != 4'hF);
        len   = 2'd0;
        unique case (1'b1)
            is_cv && (msg_status[7:5] != 3'b110): len = 2'd3;
            msg_status[7:5] == 3'b110:            len = 2'd2;
            msg_status[7:3] == 5'b11111:          len = 2'd1;
            default:                              len = 2'd0;
        endcase
    end

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs_q;

    assign rs_hit = is_cv && (msg_status == rs_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q <= 8'h00;
        end else if (xfer && is_cv) begin
            rs_q <= msg_status;
        end
    end
`else
    assign rs_hit = 1'b0;
`endif

    always_comb begin
        cur_byte = st_q;
        unique case (idx_q)
            2'd1:    cur_byte = {1'b0, d1_q};
            2'd2:    cur_byte = {1'b0, d2_q};
            default: cur_byte = st_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (xfer && (len != 2'd0)) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_START;
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && (bit_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    if (idx_q != last_q) state_d = S_LOAD;
                    else if (IDLE_GAP != 0) state_d = S_GAP;
                    else state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (tick && (gap_q == 4'd0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            bit_q   <= 3'd0;
            gap_q   <= 4'd0;
            st_q    <= 8'h00;
            d1_q    <= 7'h00;
            d2_q    <= 7'h00;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            sh_q    <= 8'h00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (xfer && (len != 2'd0)) begin
                        st_q   <= msg_status;
                        d1_q   <= msg_data1;
                        d2_q   <= msg_data2;
                        idx_q  <= rs_hit ? 2'd1 : 2'd0;
                        last_q <= len - 2'd1;
                    end
                end
                S_LOAD: begin
                    timer_q <= BIT_TOP;
                    sh_q    <= cur_byte;
                end
                S_START: begin
                    timer_q <= tick ? BIT_TOP : timer_q - 1'b1;
                    if (tick) bit_q <= 3'd0;
                end
                S_DATA: begin
                    timer_q <= tick ? BIT_TOP : timer_q - 1'b1;
                    if (tick) begin
                        bit_q <= bit_q + 3'd1;
                        sh_q  <= {1'b0, sh_q[7:1]};
                    end
                end
                S_STOP: begin
                    timer_q <= tick ? BIT_TOP : timer_q - 1'b1;
                    if (tick) begin
                        gap_q <= GAP_TOP;
                        if (idx_q != last_q) idx_q <= idx_q + 2'd1;
                    end
                end
                S_GAP: begin
                    timer_q <= tick ? BIT_TOP : timer_q - 1'b1;
                    if (tick) gap_q <= gap_q - 4'd1;
                end
                default: timer_q <= '0;
            endcase
        end
    end

    // Line and pulses are registered one cycle behind the state so they stay
    // glitch-free; byte_done lands on the last cycle of the stop bit on txd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_q  <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_START: txd_q <= 1'b0;
                S_DATA:  txd_q <= sh_q[0];
                default: txd_q <= 1'b1;
            endcase
            done_q <= (state_q == S_STOP) && tick;
            err_q  <= xfer && (len == 2'd0);
        end
    end

    assign txd       = txd_q;
    assign byte_done = done_q;
    assign msg_err   = err_q;
    assign msg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed scoreboard bench for midi_tx at 16 clocks per bit.
// Expected wire bytes are queued at stimulus time and popped as frames decode.
module tb_midi_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       msg_valid = 1'b0;
    logic       msg_ready;
    logic [7:0] msg_status = 8'h00;
    logic [6:0] msg_data1 = 7'h00;
    logic [6:0] msg_data2 = 7'h00;
    logic       txd;
    logic       busy;
    logic       byte_done;
    logic       msg_err;

    int passed = 0;
    int total  = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int low_cnt  = 0;

    logic [7:0] exp_q[$];

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs = 8'h00;
`endif

    midi_tx #(
        .CLKS_PER_BIT(CPB),
        .IDLE_GAP(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_status(msg_status),
        .msg_data1(msg_data1),
        .msg_data2(msg_data2),
        .txd(txd),
        .busy(busy),
        .byte_done(byte_done),
        .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_done) done_cnt <= done_cnt + 1;
        if (msg_err) err_cnt <= err_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (!txd) low_cnt <= low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input logic [7:0] s, input logic [6:0] a,
                            input logic [6:0] b);
        int  n;
        bit  skip;
        n = 0;
        if ((s >= 8'h80 && s <= 8'hBF) || (s >= 8'hE0 && s <= 8'hEF)) n = 3;
        else if (s >= 8'hC0 && s <= 8'hDF) n = 2;
        else if (s >= 8'hF8) n = 1;
        skip = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        if (s >= 8'h80 && s <= 8'hEF) begin
            skip = (s == rs);
            rs = s;
        end
`endif
        if (n > 0 && !skip) exp_q.push_back(s);
        if (n > 1) exp_q.push_back({1'b0, a});
        if (n > 2) exp_q.push_back({1'b0, b});
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (msg_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic send(input logic [7:0] s, input logic [6:0] a,
                        input logic [6:0] b);
        bit ok;
        wait_ready(ok);
        if (!ok) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        msg_status = s;
        msg_data1  = a;
        msg_data2  = b;
        msg_valid  = 1'b1;
        push_msg(s, a, b);
        step();
        msg_valid  = 1'b0;
        msg_status = 8'hxx;
        msg_data1  = 7'hxx;
        msg_data2  = 7'hxx;
    endtask

    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!txd) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic recv(output logic [7:0] b, output bit ok);
        b = 8'h00;
        wait_fall(ok);
        if (!ok) return;
        repeat (CPB / 2) step();
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) step();
            b[i] = txd;
        end
        repeat (CPB) step();
        check("stop_bit", {31'd0, txd}, 32'd1);
    endtask

    task automatic drain();
        logic [7:0] b;
        logic [7:0] e;
        bit         ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            recv(b, ok);
            if (!ok) begin
                check("rx_timeout", 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
            check("rx_byte", {24'd0, b}, {24'd0, e});
        end
    endtask

    initial begin
        int  d0;
        int  e0;
        int  b0;
        int  l0;
        bit  ok;
        logic [7:0] b;

        repeat (3) step();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_ready", {31'd0, msg_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, byte_done}, 32'd0);
        check("rst_err", {31'd0, msg_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // note-on, three bytes
        d0 = done_cnt;
        b0 = busy_cnt;
        send(8'h90, 7'h3C, 7'h64);
        check("busy_rise", {31'd0, busy}, 32'd1);
        drain();
        wait_ready(ok);
        repeat (3) step();
        check("noteon_done", done_cnt - d0, 3);
        check("noteon_busy", busy_cnt - b0, 3 * 10 * CPB + 3);
        check("noteon_ready", {31'd0, msg_ready}, 32'd1);

        // program change drops data2, then realtime clock
        d0 = done_cnt;
        send(8'hC1, 7'h05, 7'h7F);
        drain();
        send(8'hF8, 7'h11, 7'h22);
        drain();
        wait_ready(ok);
        repeat (3) step();
        check("pc_clk_done", done_cnt - d0, 3);

        // unsupported statuses
        e0 = err_cnt;
        b0 = busy_cnt;
        l0 = low_cnt;
        send(8'h45, 7'h01, 7'h02);
        check("err45_pulse", {31'd0, msg_err}, 32'd1);
        check("err45_ready", {31'd0, msg_ready}, 32'd1);
        step();
        check("err45_clear", {31'd0, msg_err}, 32'd0);
        send(8'hF2, 7'h01, 7'h02);
        check("errF2_pulse", {31'd0, msg_err}, 32'd1);
        step();
        check("errF2_clear", {31'd0, msg_err}, 32'd0);
        repeat (20) step();
        check("err_count", err_cnt - e0, 2);
        check("err_busy", busy_cnt - b0, 0);
        check("err_txd", low_cnt - l0, 0);

        // running status sequence with realtime in between
        d0 = done_cnt;
        send(8'h90, 7'h3C, 7'h64);
        drain();
        send(8'hF8, 7'h00, 7'h00);
        drain();
        send(8'h90, 7'h40, 7'h00);
        drain();
        wait_ready(ok);
        repeat (3) step();
`ifdef MIDI_RUNNING_STATUS_EN
        check("rs_done", done_cnt - d0, 6);
`else
        check("rs_done", done_cnt - d0, 7);
`endif

        // data bytes at maximum value
        send(8'hB0, 7'h7F, 7'h7F);
        drain();

        // reset in the middle of bit 4 of the second byte
        send(8'h90, 7'h3C, 7'h64);
        recv(b, ok);
        check("mid_first", {24'd0, b}, 32'h90);
        wait_fall(ok);
        check("mid_second_start", {31'd0, ok}, 32'd1);
        repeat (CPB * 5 + CPB / 2) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
        rs = 8'h00;
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, msg_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        send(8'h90, 7'h3C, 7'h64);
        check("post_rst_q", exp_q.size(), 3);
        drain();
        wait_ready(ok);
        check("final_ready", {31'd0, ok}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
